// File: rtl/sol1_io_mailbox_if.sv
// SOL-1 external bus plus RX/TX byte streams for the I/O mailbox.
// master = CPU / stream environment side, slave = mailbox side.
interface sol1_io_mailbox_if;
    logic [21:0] address_bus;
    logic        rd;
    logic        wr;
    logic        mem_io;
    logic        wait_n;
    logic        irq;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    modport master (
        output address_bus, rd, wr, mem_io,
        output rx_valid, rx_data, tx_ready,
        input  wait_n, irq, rx_ready, tx_valid, tx_data
    );

    modport slave (
        input  address_bus, rd, wr, mem_io,
        input  rx_valid, rx_data, tx_ready,
        output wait_n, irq, rx_ready, tx_valid, tx_data
    );
endinterface

// File: rtl/sol1_io_mailbox.sv
// SOL-1 I/O mailbox: 4-byte I/O window, wait-state FSM, RX/TX byte FIFOs.
// Optional TX->RX loopback built when SOL1_MAILBOX_LOOPBACK_EN is defined.
module sol1_io_mailbox #(
    parameter logic [15:0] BASE_ADDR   = 16'hFF80,
    parameter int          WAIT_CYCLES = 2,
    parameter int          FIFO_DEPTH  = 8
) (
    input  logic             clk,
    input  logic             arst,
    sol1_io_mailbox_if.slave bus,
    inout  wire [7:0]        data_bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] FULL_CNT = PW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACT, S_HOLD} state_t;

    state_t      state, state_nx;
    logic [3:0]  wcnt, wcnt_nx;
    logic [1:0]  reg_sel;
    logic        is_rd;
    logic        sel, strobe, acc;
    logic        wait_c;
    logic        unused_hi;

    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [PW-1:0] rx_wp, rx_rp, rx_cnt;
    logic          rx_empty, rx_full;
    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [PW-1:0] tx_wp, tx_rp, tx_cnt;
    logic          tx_empty, tx_full;
    logic [7:0]    rx_head, tx_head;

    logic       rx_irq_en, tx_irq_en, lb, tx_drop;
    logic [7:0] rdata_q, rmux, wdata;
    logic       irq_q;

    logic act_rd, act_wr, ctrl_wr;
    logic rx_pop, rx_push, tx_pop, tx_push, lb_move, drop_set;
    logic [7:0] rx_in;
    logic oe;

    assign unused_hi = ^bus.address_bus[21:16];

    assign sel    = ~bus.mem_io & (bus.address_bus[15:2] == BASE_ADDR[15:2]);
    assign strobe = ~bus.rd | ~bus.wr;
    assign acc    = sel & strobe;
    assign wdata  = data_bus;

    assign rx_cnt   = rx_wp - rx_rp;
    assign rx_empty = (rx_cnt == '0);
    assign rx_full  = (rx_cnt == FULL_CNT);
    assign tx_cnt   = tx_wp - tx_rp;
    assign tx_empty = (tx_cnt == '0);
    assign tx_full  = (tx_cnt == FULL_CNT);
    assign rx_head  = rx_mem[rx_rp[AW-1:0]];
    assign tx_head  = tx_mem[tx_rp[AW-1:0]];

    assign act_rd  = (state == S_ACT) & is_rd;
    assign act_wr  = (state == S_ACT) & ~is_rd;
    assign ctrl_wr = act_wr & (reg_sel == 2'd2);

    assign bus.rx_ready = ~rx_full & ~lb;
    assign bus.tx_valid = ~tx_empty & ~lb;
    assign bus.tx_data  = tx_empty ? 8'h00 : tx_head;
    assign bus.irq      = irq_q;
    assign bus.wait_n   = ~wait_c | arst;

    // Loopback moves the TX head into RX whenever both sides allow it.
    assign lb_move  = lb & ~tx_empty & ~rx_full;
    assign rx_pop   = act_rd & (reg_sel == 2'd0) & ~rx_empty;
    assign rx_push  = (bus.rx_valid & bus.rx_ready) | lb_move;
    assign rx_in    = lb ? tx_head : bus.rx_data;
    assign tx_pop   = (bus.tx_valid & bus.tx_ready) | lb_move;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign tx_push  = act_wr & (reg_sel == 2'd0) & (~tx_full | tx_pop);
    assign drop_set = act_wr & (reg_sel == 2'd0) & tx_full & ~tx_pop;

    // Register read mux selected by the latched low address bits.
    always_comb begin
        rmux = 8'h00;
        unique case (reg_sel)
            2'd0: rmux = rx_empty ? 8'h00 : rx_head;
            2'd1: rmux = {3'b000, tx_drop, tx_full, tx_empty,
                          rx_full, ~rx_empty};
            2'd2: rmux = {5'b00000, lb, tx_irq_en, rx_irq_en};
            2'd3: rmux = 8'(rx_cnt);
        endcase
    end

    // Next-state and wait-pin logic for the bus access sequencer.
    always_comb begin
        state_nx = state;
        wcnt_nx  = wcnt;
        wait_c   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (acc) begin
                    wait_c   = 1'b1;
                    state_nx = S_WAIT;
                    wcnt_nx  = 4'(WAIT_CYCLES - 1);
                end
            end
            S_WAIT: begin
                wait_c = 1'b1;
                if (!strobe) begin
                    state_nx = S_IDLE;
                end else if (wcnt <= 4'd1) begin
                    state_nx = S_ACT;
                    wcnt_nx  = 4'd0;
                end else begin
                    wcnt_nx = wcnt - 4'd1;
                end
            end
            S_ACT: state_nx = S_HOLD;
            S_HOLD: begin
                if (bus.rd && bus.wr) state_nx = S_IDLE;
            end
        endcase
    end

    // Sequencer state, wait counter and latched access attributes.
    always_ff @(posedge clk) begin
        if (arst) begin
            state   <= S_IDLE;
            wcnt    <= 4'd0;
            reg_sel <= 2'd0;
            is_rd   <= 1'b0;
        end else begin
            state <= state_nx;
            wcnt  <= wcnt_nx;
            if (state == S_IDLE && acc) begin
                reg_sel <= bus.address_bus[1:0];
                is_rd   <= ~bus.rd;
            end
        end
    end

    // Read data captured once per access, then held until strobe release.
    always_ff @(posedge clk) begin
        if (arst) rdata_q <= 8'h00;
        else if (act_rd) rdata_q <= rmux;
    end

    // Control bits and the sticky TX overflow flag.
    always_ff @(posedge clk) begin
        if (arst) begin
            rx_irq_en <= 1'b0;
            tx_irq_en <= 1'b0;
            tx_drop   <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                rx_irq_en <= wdata[0];
                tx_irq_en <= wdata[1];
            end
            if (drop_set) tx_drop <= 1'b1;
            else if (ctrl_wr && wdata[7]) tx_drop <= 1'b0;
        end
    end

`ifdef SOL1_MAILBOX_LOOPBACK_EN
    logic lb_q;
    // Loopback enable bit, only present in loopback builds.
    always_ff @(posedge clk) begin
        if (arst) lb_q <= 1'b0;
        else if (ctrl_wr) lb_q <= wdata[2];
    end
    assign lb = lb_q;
`else
    assign lb = 1'b0;
`endif

    // RX FIFO pointers.
    always_ff @(posedge clk) begin
        if (arst) begin
            rx_wp <= '0;
            rx_rp <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + PW'(1);
            if (rx_pop)  rx_rp <= rx_rp + PW'(1);
        end
    end

    // RX FIFO storage.
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_in;
    end

    // TX FIFO pointers.
    always_ff @(posedge clk) begin
        if (arst) begin
            tx_wp <= '0;
            tx_rp <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + PW'(1);
            if (tx_pop)  tx_rp <= tx_rp + PW'(1);
        end
    end

    // TX FIFO storage.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp[AW-1:0]] <= wdata;
    end

    // Registered level interrupt.
    always_ff @(posedge clk) begin
        if (arst) irq_q <= 1'b0;
        else irq_q <= (rx_irq_en & ~rx_empty) | (tx_irq_en & tx_empty);
    end

    assign oe = ~arst & is_rd & ~bus.rd & sel &
                (state != S_IDLE);
    assign data_bus = oe ? ((state == S_WAIT) ? rmux : rdata_q) : 8'bz;
endmodule

// File: tb/tb_sol1_io_mailbox.sv
// Directed bench for sol1_io_mailbox: table of bus/stream operations
// plus hand sequences for draining, interrupts, decode misses and aborts.
module tb_sol1_io_mailbox;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       arst;
    wire  [7:0] data_bus;
    logic [7:0] drv;
    logic       drv_en;
    assign data_bus = drv_en ? drv : 8'bz;

    sol1_io_mailbox_if bus();

    sol1_io_mailbox dut (
        .clk(clk),
        .arst(arst),
        .bus(bus.slave),
        .data_bus(data_bus)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        int          op;
        logic [15:0] addr;
        logic [7:0]  d;
        logic [7:0]  exp;
    } vec_t;

    vec_t tbl[21];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cpu_access(input bit is_read, input logic [15:0] addr,
                              input logic [7:0] wd, output logic [7:0] rdat,
                              output int low, output logic irq_s);
        @(negedge clk);
        bus.address_bus = {6'h00, addr};
        bus.mem_io = 1'b0;
        if (is_read) begin
            bus.rd = 1'b0;
        end else begin
            bus.wr = 1'b0;
            drv = wd;
            drv_en = 1'b1;
        end
        low = 0;
        #1;
        while (bus.wait_n == 1'b0 && low < 40) begin
            low++;
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        #1;
        rdat = data_bus;
        irq_s = bus.irq;
        bus.rd = 1'b1;
        bus.wr = 1'b1;
        drv_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic rd_chk(input string name, input logic [15:0] addr,
                          input logic [7:0] exp);
        logic [7:0] r;
        int lo;
        logic iq;
        cpu_access(1'b1, addr, 8'h00, r, lo, iq);
        check(name, r, exp);
    endtask

    task automatic wr_reg(input logic [15:0] addr, input logic [7:0] d);
        logic [7:0] r;
        int lo;
        logic iq;
        cpu_access(1'b0, addr, d, r, lo, iq);
    endtask

    task automatic rx_push(input logic [7:0] d);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data = d;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic miss_access(input string name, input logic mio,
                               input logic [15:0] addr);
        int lo;
        @(negedge clk);
        bus.address_bus = {6'h00, addr};
        bus.mem_io = mio;
        bus.rd = 1'b0;
        lo = 0;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (bus.wait_n == 1'b0) lo++;
            @(negedge clk);
        end
        bus.rd = 1'b1;
        bus.mem_io = 1'b0;
        check(name, lo, 0);
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] r;
        int lo;
        logic iq;

        tbl[0] = '{0, 16'hFF81, 8'h00, 8'h04};
        tbl[1] = '{2, 16'h0000, 8'h11, 8'h00};
        tbl[2] = '{2, 16'h0000, 8'h22, 8'h00};
        tbl[3] = '{2, 16'h0000, 8'h33, 8'h00};
        tbl[4] = '{0, 16'hFF83, 8'h00, 8'h03};
        tbl[5] = '{0, 16'hFF80, 8'h00, 8'h11};
        tbl[6] = '{0, 16'hFF80, 8'h00, 8'h22};
        tbl[7] = '{0, 16'hFF80, 8'h00, 8'h33};
        tbl[8] = '{0, 16'hFF83, 8'h00, 8'h00};
        tbl[9] = '{0, 16'hFF80, 8'h00, 8'h00};
        tbl[10] = '{0, 16'hFF81, 8'h00, 8'h04};
        for (int i = 0; i < 8; i++)
            tbl[11 + i] = '{1, 16'hFF80, 8'hA0 + 8'(i), 8'h00};
        tbl[19] = '{1, 16'hFF80, 8'hFF, 8'h00};
        tbl[20] = '{0, 16'hFF81, 8'h00, 8'h18};

        arst = 1'b1;
        drv = 8'h00;
        drv_en = 1'b0;
        bus.address_bus = 22'h0;
        bus.rd = 1'b1;
        bus.wr = 1'b1;
        bus.mem_io = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data = 8'h00;
        bus.tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        arst = 1'b0;
        #1;
        check("rst_wait_n", bus.wait_n, 1);
        check("rst_irq", bus.irq, 0);
        check("rst_rx_ready", bus.rx_ready, 1);
        check("rst_tx_valid", bus.tx_valid, 0);
        check("rst_tx_data", bus.tx_data, 8'h00);

        for (int i = 0; i < 21; i++) begin
            if (tbl[i].op == 2) begin
                rx_push(tbl[i].d);
            end else begin
                cpu_access(tbl[i].op == 0, tbl[i].addr, tbl[i].d,
                           r, lo, iq);
                check($sformatf("vec%0d_wait", i), lo, 2);
                if (tbl[i].op == 0)
                    check($sformatf("vec%0d_data", i), r, tbl[i].exp);
            end
        end

        @(negedge clk);
        bus.tx_ready = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("tx_valid%0d", i), bus.tx_valid, 1);
            check($sformatf("tx_data%0d", i), bus.tx_data, 8'hA0 + 8'(i));
            @(negedge clk);
            #1;
        end
        check("tx_drained", bus.tx_valid, 0);
        bus.tx_ready = 1'b0;
        rd_chk("status_drop_kept", 16'hFF81, 8'h14);
        wr_reg(16'hFF82, 8'h80);
        rd_chk("status_drop_clr", 16'hFF81, 8'h04);
        rd_chk("ctrl_bit7_zero", 16'hFF82, 8'h00);

        wr_reg(16'hFF82, 8'h01);
        rd_chk("ctrl_rx_irq", 16'hFF82, 8'h01);
        check("irq_idle", bus.irq, 0);
        rx_push(8'h77);
        #1;
        check("irq_not_yet", bus.irq, 0);
        @(negedge clk);
        #1;
        check("irq_rise", bus.irq, 1);
        cpu_access(1'b1, 16'hFF80, 8'h00, r, lo, iq);
        check("irq_pop_data", r, 8'h77);
        check("irq_hold_after_pop", iq, 1);
        #1;
        check("irq_fall", bus.irq, 0);
        wr_reg(16'hFF82, 8'h00);

        rx_push(8'h99);
        miss_access("mem_io_miss", 1'b1, 16'hFF80);
        miss_access("addr_miss", 1'b0, 16'hFF84);
        rd_chk("miss_no_pop", 16'hFF83, 8'h01);
        @(negedge clk);
        bus.address_bus = {6'h00, 16'hFF80};
        bus.mem_io = 1'b0;
        bus.rd = 1'b0;
        @(negedge clk);
        bus.rd = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("abort_wait_n", bus.wait_n, 1);
        rd_chk("abort_no_pop", 16'hFF83, 8'h01);
        rd_chk("abort_data", 16'hFF80, 8'h99);

`ifdef SOL1_MAILBOX_LOOPBACK_EN
        wr_reg(16'hFF82, 8'h04);
        rd_chk("lb_ctrl", 16'hFF82, 8'h04);
        check("lb_rx_ready", bus.rx_ready, 0);
        wr_reg(16'hFF80, 8'h5A);
        check("lb_tx_valid", bus.tx_valid, 0);
        rd_chk("lb_rxcount", 16'hFF83, 8'h01);
        rd_chk("lb_data", 16'hFF80, 8'h5A);
        check("lb_tx_valid2", bus.tx_valid, 0);
        wr_reg(16'hFF82, 8'h00);
`else
        wr_reg(16'hFF82, 8'h04);
        rd_chk("no_lb_ctrl", 16'hFF82, 8'h00);
        wr_reg(16'hFF82, 8'h00);
`endif

        for (int i = 0; i < 8; i++) rx_push(8'hC0 + 8'(i));
        #1;
        check("rx_full_ready", bus.rx_ready, 0);
        rx_push(8'hEE);
        rd_chk("rx_full_status", 16'hFF81, 8'h07);
        rd_chk("rx_full_count", 16'hFF83, 8'h08);
        rd_chk("rx_full_head", 16'hFF80, 8'hC0);
        rd_chk("rx_after_pop", 16'hFF83, 8'h07);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
